dcim_mac_accumulator: RTL and testbench



---
 rtl/dcim_pkg.sv | 21 ++
 rtl/dcim_sm2tc.sv | 13 +
 rtl/dcim_mac_accumulator.sv | 73 +++++++
 tb/tb_dcim_mac_accumulator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dcim_pkg.sv
// dcim_pkg: shared FSM states, default widths and the saturating adder for the DCIM MAC accumulator
package dcim_pkg;
    localparam int PROD_W = 16;
    localparam int ACC_W = 24;
    localparam int LEN_W = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    typedef struct packed {
        logic signed [63:0] sum;
        logic ovf;
    } sat_t;
    function automatic sat_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        sat_t r;
        logic signed [63:0] s, hi, lo;
        s = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.ovf = (s > hi) || (s < lo);
        r.sum = s > hi ? hi : s < lo ? lo : s;
        return r;
    endfunction
endpackage

// File: rtl/dcim_sm2tc.sv
// dcim_sm2tc: sign-magnitude product (prod) to ACC_W-bit two's complement (tc); negative zero maps to 0
module dcim_sm2tc #(
    parameter int PROD_W = dcim_pkg::PROD_W,
    parameter int ACC_W = dcim_pkg::ACC_W
) (
    input  logic [PROD_W-1:0]       prod,
    output logic signed [ACC_W-1:0] tc
);
    import dcim_pkg::*;
    logic [ACC_W-1:0] mag;
    assign mag = {{(ACC_W - PROD_W + 1){1'b0}}, prod[PROD_W-2:0]};
    assign tc = prod[PROD_W-1] ? -mag : mag;
endmodule

// File: rtl/dcim_mac_accumulator.sv
// dcim_mac_accumulator: saturating dot-product accumulator; start/cfg_len begin a run, in_valid/in_ready/in_prod feed products, out_valid/out_ready/out_acc/out_ovf return the result, busy flags ACCUM|DONE
module dcim_mac_accumulator #(
    parameter int PROD_W = dcim_pkg::PROD_W,
    parameter int ACC_W = dcim_pkg::ACC_W,
    parameter int LEN_W = dcim_pkg::LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PROD_W-1:0]       in_prod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_ovf,
    output logic                    busy
);
    import dcim_pkg::*;
    state_t state;
    logic [LEN_W-1:0] len, count, count_nx;
    logic signed [ACC_W-1:0] prod_tc;
    sat_t r;
    dcim_sm2tc #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_conv (.prod(in_prod), .tc(prod_tc));
    assign r = sat_add(64'(out_acc), 64'(prod_tc), ACC_W);
    assign count_nx = count + LEN_W'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len <= '0;
            count <= '0;
            out_acc <= '0;
            out_ovf <= 1'b0;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    out_acc <= '0;
                    out_ovf <= 1'b0;
                    count <= '0;
                    len <= cfg_len;
                    busy <= 1'b1;
                    if (cfg_len != '0) begin
                        state <= ACCUM;
                        in_ready <= 1'b1;
                    end else begin
                        state <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                ACCUM: if (in_valid) begin
                    out_acc <= r.sum[ACC_W-1:0];
                    out_ovf <= out_ovf | r.ovf;
                    count <= count_nx;
                    if (count_nx == len) begin
                        state <= DONE;
                        in_ready <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcim_mac_accumulator.sv
// tb_dcim_mac_accumulator: directed checks of the default-width and 16-bit-accumulator MAC instances
module tb_dcim_mac_accumulator;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [7:0] cfg_len;
  logic [15:0] in_prod;
  logic in_ready, out_valid, out_ovf, busy;
  logic signed [23:0] out_acc;
  logic in_ready16, out_valid16, out_ovf16, busy16;
  logic signed [15:0] out_acc16;
  int ncmp = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  dcim_mac_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );
  dcim_mac_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_prod(in_prod),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .out_ovf(out_ovf16), .busy(busy16)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_len = 8'd0; in_prod = 16'h0000;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_acc", $unsigned(out_acc), 24'h000000);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    start = 1'b1; cfg_len = 8'd3;
    tick();
    start = 1'b0;
    chk("basic_in_ready", in_ready, 1'b1);
    chk("basic_busy", busy, 1'b1);
    chk("basic_no_valid", out_valid, 1'b0);
    in_valid = 1'b1; in_prod = 16'h0005;
    tick();
    in_prod = 16'h8003;
    tick();
    in_prod = 16'h000A;
    tick();
    in_valid = 1'b0;
    chk("basic_out_valid", out_valid, 1'b1);
    chk("basic_out_acc", $unsigned(out_acc), 24'd12);
    chk("basic_out_ovf", out_ovf, 1'b0);
    chk("basic_in_ready_low", in_ready, 1'b0);
    chk("basic_acc16", $unsigned(out_acc16), 16'd12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_idle_valid", out_valid, 1'b0);
    chk("basic_idle_busy", busy, 1'b0);
    start = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 16'h8000;
    tick();
    in_valid = 1'b0; in_prod = 16'h0007;
    chk("negzero_acc", $unsigned(out_acc), 24'd0);
    tick(); tick(); tick();
    chk("stall_in_ready", in_ready, 1'b1);
    chk("stall_no_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_out_acc", $unsigned(out_acc), 24'd7);
    start = 1'b1; cfg_len = 8'd5; in_valid = 1'b1; in_prod = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_acc", $unsigned(out_acc), 24'd7);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_valid", out_valid, 1'b0);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_idle_in_ready", in_ready, 1'b0);
    start = 1'b1; cfg_len = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_out_valid", out_valid, 1'b1);
    chk("zero_out_acc", $unsigned(out_acc), 24'd0);
    chk("zero_in_ready", in_ready, 1'b0);
    chk("zero_busy", busy, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("zero_idle_valid", out_valid, 1'b0);
    start = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 16'h7FFF;
    tick(); tick();
    in_valid = 1'b0;
    chk("satp_acc16", $unsigned(out_acc16), 16'h7FFF);
    chk("satp_ovf16", out_ovf16, 1'b1);
    chk("satp_acc24", $unsigned(out_acc), 24'h00FFFE);
    chk("satp_ovf24", out_ovf, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0;
    chk("ovf_cleared16", out_ovf16, 1'b0);
    in_valid = 1'b1; in_prod = 16'hFFFF;
    tick(); tick();
    in_valid = 1'b0;
    chk("satn_acc16", $unsigned(out_acc16), 16'h8000);
    chk("satn_ovf16", out_ovf16, 1'b1);
    chk("satn_acc24", $unsigned(out_acc), 24'hFF0002);
    chk("satn_ovf24", out_ovf, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b1; cfg_len = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 16'h0010;
    tick(); tick();
    chk("mid_acc", $unsigned(out_acc), 24'h000020);
    rst = 1'b1;
    #1;
    chk("mrst_acc", $unsigned(out_acc), 24'd0);
    chk("mrst_in_ready", in_ready, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1; cfg_len = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 16'h0003;
    tick();
    in_valid = 1'b0;
    chk("after_rst_valid", out_valid, 1'b1);
    chk("after_rst_acc", $unsigned(out_acc), 24'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_rst_idle", out_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
